// File: rtl/step_pkg.sv
// Shared definitions for the step pulse generator / meter pair.
// Holds the measurement FSM state encoding and the default counter widths,
// so the generator and the meter agree on count and reduction widths.
package step_pkg;

  // Default width of the pulse counter (matches generator count width).
  localparam int CNT_W_DEF = 31;
  // Default width of period / width / timeout counters.
  localparam int PER_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    DONE       = 2'd3
  } step_state_t;

endpackage

// File: rtl/step_edge_sync.sv
// Step line synchroniser and edge detector.
// Two flops bring the asynchronous step line into the clk domain; a third
// flop holds the previous synchronised value for edge detection. Rising and
// falling edges see the same two-cycle latency, so intervals measured between
// any pair of edges are exact.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   step_in  asynchronous step line
//   rise     one-cycle pulse on a synchronised rising edge
//   fall     one-cycle pulse on a synchronised falling edge
module step_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic step_in,
  output logic rise,
  output logic fall
);

  // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3
  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], step_in};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/step_pulse_meter.sv
// Step pulse meter: receive-side checker for step bursts.
// Counts rising edges of a burst on the synchronised step line and measures
// the period between the two most recent rises and the high width of the most
// recent pulse, in clk cycles. A burst ends when no rise is seen for
// 'timeout' cycles after the last one (timeout = 0 disables the end check).
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   step_in      asynchronous step line
//   arm          one-cycle start strobe; clears results, starts a measurement
//   timeout      idle cycles after the last rise that end a burst
//   pulse_count  rising edges counted in the current / last burst
//   period       cycles between the two most recent rises
//   high_width   cycles from the most recent rise to its falling edge
//   busy         measurement in progress (waiting for first rise or measuring)
//   done         burst finished, results frozen until the next arm
//   jitter       sticky: a new period differed from the previous one
module step_pulse_meter
  import step_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_in,
  input  logic             arm,
  input  logic [PER_W-1:0] timeout,
  output logic [CNT_W-1:0] pulse_count,
  output logic [PER_W-1:0] period,
  output logic [PER_W-1:0] high_width,
  output logic             busy,
  output logic             done,
  output logic             jitter
);

  logic rise;
  logic fall;

  step_edge_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .step_in (step_in),
    .rise    (rise),
    .fall    (fall)
  );

  step_state_t      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PER_W-1:0] period_reg, period_next;
  logic [PER_W-1:0] high_width_reg, high_width_next;
  logic             jitter_reg, jitter_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  // gap: cycles since the last rise; high: cycles since the last rise, used
  // to capture the width at the first following fall.
  logic [PER_W-1:0] gap_reg, gap_next;
  logic [PER_W-1:0] high_reg, high_next;
  // Set on each rise, cleared at the first fall so later falls are ignored.
  logic             high_open_reg, high_open_next;

  logic [CNT_W-1:0] count_inc;
  logic [PER_W-1:0] gap_inc;
  logic [PER_W-1:0] high_inc;

  // Saturating increments: counters hold at all-ones rather than wrapping.
  assign count_inc = (&count_reg) ? count_reg : count_reg + CNT_W'(1);
  assign gap_inc   = (&gap_reg)   ? gap_reg   : gap_reg + PER_W'(1);
  assign high_inc  = (&high_reg)  ? high_reg  : high_reg + PER_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      period_reg     <= '0;
      high_width_reg <= '0;
      jitter_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      gap_reg        <= '0;
      high_reg       <= '0;
      high_open_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      period_reg     <= period_next;
      high_width_reg <= high_width_next;
      jitter_reg     <= jitter_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      gap_reg        <= gap_next;
      high_reg       <= high_next;
      high_open_reg  <= high_open_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    period_next     = period_reg;
    high_width_next = high_width_reg;
    jitter_next     = jitter_reg;
    gap_next        = gap_reg;
    high_next       = high_reg;
    high_open_next  = high_open_reg;

    if (arm) begin
      // Arm restarts from any state and swallows a same-cycle edge.
      state_next      = WAIT_FIRST;
      count_next      = '0;
      period_next     = '0;
      high_width_next = '0;
      jitter_next     = 1'b0;
      gap_next        = '0;
      high_next       = '0;
      high_open_next  = 1'b0;
    end else begin
      case (state_reg)
        WAIT_FIRST: begin
          if (rise) begin
            state_next     = MEASURE;
            count_next     = CNT_W'(1);
            gap_next       = PER_W'(1);
            high_next      = PER_W'(1);
            high_open_next = 1'b1;
          end
        end
        MEASURE: begin
          gap_next  = gap_inc;
          high_next = high_inc;
          if (rise) begin
            count_next  = count_inc;
            period_next = gap_reg;
            // Only compare once a previous period has been stored.
            if ((count_reg >= CNT_W'(2)) && (gap_reg != period_reg)) begin
              jitter_next = 1'b1;
            end
            gap_next       = PER_W'(1);
            high_next      = PER_W'(1);
            high_open_next = 1'b1;
          end else begin
            if (fall && high_open_reg) begin
              high_width_next = high_reg;
              high_open_next  = 1'b0;
            end
            if ((timeout != '0) && (gap_reg == timeout)) begin
              state_next = DONE;
            end
          end
        end
        default: begin
          // IDLE and DONE ignore the step line entirely.
        end
      endcase
    end

    busy_next = (state_next == WAIT_FIRST) || (state_next == MEASURE);
    done_next = (state_next == DONE);
  end

  assign pulse_count = count_reg;
  assign period      = period_reg;
  assign high_width  = high_width_reg;
  assign jitter      = jitter_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_step_pulse_meter.sv
// Testbench for step_pulse_meter: table of uniform bursts, hand-written
// corner sequences, and randomized bursts checked against a burst-level model.
module tb_step_pulse_meter;

  localparam int CNT_W = 31;
  localparam int PER_W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             step_in = 1'b0;
  logic             arm = 1'b0;
  logic [PER_W-1:0] timeout = '0;
  logic [CNT_W-1:0] pulse_count;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] high_width;
  logic             busy;
  logic             done;
  logic             jitter;

  step_pulse_meter #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .step_in     (step_in),
    .arm         (arm),
    .timeout     (timeout),
    .pulse_count (pulse_count),
    .period      (period),
    .high_width  (high_width),
    .busy        (busy),
    .done        (done),
    .jitter      (jitter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int n;
    int hi;
    int lo;
    int tmo;
    int exp_cnt;
    int exp_per;
    int exp_hi;
    int exp_jit;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge; step_in high for h cycles, then low for l.
  task automatic pulse(input int h, input int l, output int rise_cyc);
    step_in = 1'b1;
    rise_cyc = cyc;
    tick(h);
    step_in = 1'b0;
    tick(l);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int at_cyc);
    int k;
    k = 0;
    while (!done && k < bound) begin
      tick(1);
      k++;
    end
    at_cyc = cyc;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=timeout required=done within %0d cycles", bound);
    end
  endtask

  task automatic check_results(input string tag, input int c, input int p, input int h, input int j);
    check({tag, ".pulse_count"}, 64'(pulse_count), 64'(c));
    check({tag, ".period"}, 64'(period), 64'(p));
    check({tag, ".high_width"}, 64'(high_width), 64'(h));
    check({tag, ".jitter"}, 64'(jitter), 64'(j));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc, dc, tmp;
    int hs[$];
    int ls[$];
    int n, tmo, exp_per, exp_jit;

    vecs[0] = '{n:4, hi:5, lo:5, tmo:20, exp_cnt:4, exp_per:10, exp_hi:5, exp_jit:0};
    vecs[1] = '{n:1, hi:1, lo:1, tmo:20, exp_cnt:1, exp_per:0,  exp_hi:1, exp_jit:0};
    vecs[2] = '{n:3, hi:3, lo:4, tmo:15, exp_cnt:3, exp_per:7,  exp_hi:3, exp_jit:0};
    vecs[3] = '{n:2, hi:1, lo:3, tmo:10, exp_cnt:2, exp_per:4,  exp_hi:1, exp_jit:0};

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check_results("reset", 0, 0, 0, 0);
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    reset_n = 1'b1;
    tick(2);

    // Edges before any arm are ignored
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    check("idle.pulse_count", 64'(pulse_count), 64'(0));
    check("idle.busy", 64'(busy), 64'(0));

    // Table of uniform bursts
    for (int i = 0; i < 4; i++) begin
      timeout = PER_W'(vecs[i].tmo);
      do_arm();
      $display("vec %0d: n=%0d hi=%0d lo=%0d tmo=%0d", i, vecs[i].n, vecs[i].hi, vecs[i].lo, vecs[i].tmo);
      check($sformatf("vec%0d.busy_after_arm", i), 64'(busy), 64'(1));
      check($sformatf("vec%0d.done_after_arm", i), 64'(done), 64'(0));
      for (int p = 0; p < vecs[i].n; p++) pulse(vecs[i].hi, vecs[i].lo, rc);
      wait_done(200, dc);
      check($sformatf("vec%0d.done_latency", i), 64'(dc - rc), 64'(vecs[i].tmo + 3));
      check_results($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_per, vecs[i].exp_hi, vecs[i].exp_jit);
      check($sformatf("vec%0d.busy_done", i), 64'(busy), 64'(0));
    end

    // Periods 10,10,12 -> jitter set by the 12, sticky until arm
    timeout = PER_W'(30);
    do_arm();
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    pulse(5, 7, rc);
    check("jit.before", 64'(jitter), 64'(0));
    check("jit.period10", 64'(period), 64'(10));
    pulse(5, 5, rc);
    check("jit.after", 64'(jitter), 64'(1));
    check("jit.period12", 64'(period), 64'(12));
    wait_done(200, dc);
    check("jit.in_done", 64'(jitter), 64'(1));
    $display("jitter seq: pulse_count=%0d period=%0d jitter=%0d", pulse_count, period, jitter);
    do_arm();
    check("jit.cleared", 64'(jitter), 64'(0));
    check("jit.done_cleared", 64'(done), 64'(0));

    // Arm mid-burst, coincident with the synchronised rise of a 4th pulse
    timeout = PER_W'(20);
    do_arm();
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    check("rearm.count3", 64'(pulse_count), 64'(3));
    step_in = 1'b1;
    tick(2);
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    check("rearm.cleared", 64'(pulse_count), 64'(0));
    tick(2);
    step_in = 1'b0;
    tick(5);
    check("rearm.edge_ignored", 64'(pulse_count), 64'(0));
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    wait_done(200, dc);
    check_results("rearm", 2, 10, 5, 0);

    // Line already high at arm: no rise until it falls and rises again
    step_in = 1'b1;
    tick(3);
    do_arm();
    tick(8);
    check("high_at_arm.busy", 64'(busy), 64'(1));
    check("high_at_arm.count", 64'(pulse_count), 64'(0));
    step_in = 1'b0;
    tick(5);
    pulse(4, 4, rc);
    wait_done(200, dc);
    check_results("high_at_arm", 1, 0, 4, 0);

    // timeout = 0 never ends the burst
    timeout = '0;
    do_arm();
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    tick(1000);
    check("tmo0.busy", 64'(busy), 64'(1));
    check("tmo0.done", 64'(done), 64'(0));
    check("tmo0.count", 64'(pulse_count), 64'(3));
    $display("timeout0 seq: busy=%0d done=%0d pulse_count=%0d", busy, done, pulse_count);

    // Asynchronous reset mid-MEASURE
    timeout = PER_W'(20);
    do_arm();
    pulse(5, 5, rc);
    step_in = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    check_results("async_rst", 0, 0, 0, 0);
    check("async_rst.busy", 64'(busy), 64'(0));
    tick(2);
    reset_n = 1'b1;
    step_in = 1'b0;
    tick(3);
    pulse(5, 5, rc);
    pulse(5, 5, rc);
    check("post_rst.count", 64'(pulse_count), 64'(0));
    check("post_rst.busy", 64'(busy), 64'(0));

    // Randomized bursts against a burst-level model
    for (int b = 0; b < 20; b++) begin
      n = $urandom_range(1, 6);
      tmo = $urandom_range(20, 40);
      hs.delete();
      ls.delete();
      for (int p = 0; p < n; p++) begin
        tmp = $urandom_range(1, 6);
        hs.push_back(tmp);
        tmp = $urandom_range(1, 6);
        ls.push_back(tmp);
      end
      // Period = spacing of the last two rises; jitter = any change between
      // consecutive spacings.
      exp_per = (n >= 2) ? hs[n-2] + ls[n-2] : 0;
      exp_jit = 0;
      for (int k = 1; k <= n - 2; k++) begin
        if ((hs[k] + ls[k]) != (hs[k-1] + ls[k-1])) exp_jit = 1;
      end
      timeout = PER_W'(tmo);
      do_arm();
      for (int p = 0; p < n; p++) pulse(hs[p], ls[p], rc);
      wait_done(200, dc);
      $display("rand %0d: n=%0d tmo=%0d pulse_count=%0d period=%0d high_width=%0d jitter=%0d",
               b, n, tmo, pulse_count, period, high_width, jitter);
      check($sformatf("rand%0d.done_latency", b), 64'(dc - rc), 64'(tmo + 3));
      check_results($sformatf("rand%0d", b), n, exp_per, hs[n-1], exp_jit);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
